// File: rtl/br32_pkg.sv
// Shared br32 definitions: exception causes, the system-register address
// space (including the interrupt-controller window 0x1010..0x1015) and
// interrupt-id width helpers.
// No ports (package).
package br32_pkg;

  typedef enum logic [3:0] {
    EXN_NONE    = 4'd0,
    EXN_ILLEGAL = 4'd1,
    EXN_SYSCALL = 4'd2,
    EXN_IRQ     = 4'd3
  } exn_e;

  typedef enum logic [31:0] {
    SR_STATUS       = 32'h0000_1000,
    SR_EPC          = 32'h0000_1001,
    SR_CAUSE        = 32'h0000_1002,
    SR_IRQ_EN       = 32'h0000_1010,
    SR_IRQ_MODE     = 32'h0000_1011,
    SR_IRQ_PEND     = 32'h0000_1012,
    SR_IRQ_CLAIM    = 32'h0000_1013,
    SR_IRQ_COMPLETE = 32'h0000_1014,
    SR_IRQ_INSVC    = 32'h0000_1015
  } sreg_e;

  localparam int IRQ_NSRC = 8;
  // Wide enough to hold id+1 for every source (0 means "none").
  localparam int IRQ_ID_W = $clog2(IRQ_NSRC + 1);

  function automatic int irq_id_w(input int nsrc);
    return $clog2(nsrc + 1);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set bit of eligible.
// Ports:
//   eligible [NSRC-1:0] in  - candidate sources
//   valid               out - any bit set
//   id       [ID_W-1:0] out - index of the lowest set bit (0 when !valid)
module irq_prio_enc #(
  parameter int NSRC = 8,
  parameter int ID_W = 4
) (
  input  logic [NSRC-1:0] eligible,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the lowest index is the last to win.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: merges NSRC sources into one registered irq line,
// with per-source enable, edge/level mode, pending and in-service state and a
// claim/complete handshake over the mfsr/mtsr system-register path.
// Optional build macro IRQ_CTRL_SYNC_EN: adds a 2-flop synchronizer on src
// (src-to-irq latency 4 cycles instead of 2).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   src      [NSRC-1:0]  - raw interrupt lines
//   sr_addr  [31:0]      - system-register address
//   sr_we / sr_re        - mtsr / mfsr one-cycle strobes
//   sr_wdata [31:0]      - write data
//   sr_rdata [31:0]      - combinational read data for sr_addr
//   irq                  - registered interrupt request
module irq_ctrl
  import br32_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     sr_addr,
  input  logic            sr_we,
  input  logic            sr_re,
  input  logic [31:0]     sr_wdata,
  output logic [31:0]     sr_rdata,
  output logic            irq
);

  localparam int ID_W = irq_id_w(NSRC);

  logic [NSRC-1:0] src_s;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] en;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] insvc;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync_1;
  logic [NSRC-1:0] sync_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= src;
      sync_2 <= sync_1;
    end
  end

  assign src_s = sync_2;
`else
  assign src_s = src;
`endif

  logic [NSRC-1:0] rise;
  assign rise = src_s & ~src_q;

  // blocked[i] = some source at or above i's priority is in service.
  logic [NSRC-1:0] blocked;
  always_comb begin
    logic acc;
    acc     = 1'b0;
    blocked = '0;
    for (int i = 0; i < NSRC; i++) begin
      acc        = acc | insvc[i];
      blocked[i] = acc;
    end
  end

  logic [NSRC-1:0] eligible;
  assign eligible = pend & en & ~blocked;

  logic            enc_valid;
  logic [ID_W-1:0] enc_id;

  irq_prio_enc #(
    .NSRC (NSRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .eligible (eligible),
    .valid    (enc_valid),
    .id       (enc_id)
  );

  logic sel_en, sel_mode, sel_pend, sel_claim, sel_cmpl, sel_insvc;
  assign sel_en    = (sr_addr == SR_IRQ_EN);
  assign sel_mode  = (sr_addr == SR_IRQ_MODE);
  assign sel_pend  = (sr_addr == SR_IRQ_PEND);
  assign sel_claim = (sr_addr == SR_IRQ_CLAIM);
  assign sel_cmpl  = (sr_addr == SR_IRQ_COMPLETE);
  assign sel_insvc = (sr_addr == SR_IRQ_INSVC);

  logic            claim_hit;
  logic [NSRC-1:0] claim_mask;
  assign claim_hit  = sr_re && sel_claim && enc_valid;
  assign claim_mask = claim_hit ? (NSRC'(1) << enc_id) : '0;

  // Only ids 1..NSRC name a source; anything else written to COMPLETE is dropped.
  logic            cmpl_hit;
  logic [ID_W-1:0] cmpl_idx;
  logic [NSRC-1:0] cmpl_mask;
  assign cmpl_hit  = sr_we && sel_cmpl && (sr_wdata != 32'd0) && (sr_wdata <= 32'(NSRC));
  assign cmpl_idx  = sr_wdata[ID_W-1:0] - ID_W'(1);
  assign cmpl_mask = cmpl_hit ? (NSRC'(1) << cmpl_idx) : '0;

  logic [NSRC-1:0] w1c_mask;
  assign w1c_mask = (sr_we && sel_pend) ? sr_wdata[NSRC-1:0] : '0;

  // Edge sources: clears first, then a fresh rising edge wins.
  // Level sources simply follow the (synchronized) line.
  logic [NSRC-1:0] pend_n;
  assign pend_n = (mode & ((pend & ~(claim_mask | w1c_mask)) | rise))
                | (~mode & src_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      en    <= '0;
      mode  <= '0;
      pend  <= '0;
      insvc <= '0;
      irq   <= 1'b0;
    end else begin
      src_q <= src_s;
      pend  <= pend_n;
      insvc <= (insvc | claim_mask) & ~cmpl_mask;
      irq   <= |eligible;
      if (sr_we && sel_en)   en   <= sr_wdata[NSRC-1:0];
      if (sr_we && sel_mode) mode <= sr_wdata[NSRC-1:0];
    end
  end

  always_comb begin
    sr_rdata = '0;
    if (sel_en)    sr_rdata[NSRC-1:0] = en;
    if (sel_mode)  sr_rdata[NSRC-1:0] = mode;
    if (sel_pend)  sr_rdata[NSRC-1:0] = pend;
    if (sel_insvc) sr_rdata[NSRC-1:0] = insvc;
    if (sel_claim && enc_valid) sr_rdata = 32'(enc_id) + 32'd1;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  localparam int NSRC = 8;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  localparam logic [31:0] A_EN    = 32'h1010;
  localparam logic [31:0] A_MODE  = 32'h1011;
  localparam logic [31:0] A_PEND  = 32'h1012;
  localparam logic [31:0] A_CLAIM = 32'h1013;
  localparam logic [31:0] A_CMPL  = 32'h1014;
  localparam logic [31:0] A_INSVC = 32'h1015;

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] src;
  logic [31:0]     sr_addr;
  logic            sr_we;
  logic            sr_re;
  logic [31:0]     sr_wdata;
  logic [31:0]     sr_rdata;
  logic            irq;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .sr_addr  (sr_addr),
    .sr_we    (sr_we),
    .sr_re    (sr_re),
    .sr_wdata (sr_wdata),
    .sr_rdata (sr_rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [NSRC-1:0] m_en, m_mode, m_pend, m_insvc, m_prev, m_s1, m_s2;
  logic            m_irq;

  // id+1 of the highest-priority source allowed to interrupt, 0 if none.
  function automatic int m_claim_val();
    for (int i = 0; i < NSRC; i++) begin
      if (m_insvc[i]) return 0;
      if (m_pend[i] && m_en[i]) return i + 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      A_EN:    return 32'(m_en);
      A_MODE:  return 32'(m_mode);
      A_PEND:  return 32'(m_pend);
      A_INSVC: return 32'(m_insvc);
      A_CLAIM: return 32'(m_claim_val());
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [NSRC-1:0] seen, np, ni;
    int cid, wid;
    if (rst) begin
      m_en <= '0; m_mode <= '0; m_pend <= '0; m_insvc <= '0;
      m_prev <= '0; m_s1 <= '0; m_s2 <= '0; m_irq <= 1'b0;
    end else begin
      seen = (LAT == 4) ? m_s2 : src;
      cid  = (sr_re && sr_addr == A_CLAIM) ? m_claim_val() : 0;
      wid  = (sr_we && sr_addr == A_CMPL && sr_wdata <= 32'(NSRC)) ? int'(sr_wdata) : 0;
      np = m_pend;
      ni = m_insvc;
      for (int i = 0; i < NSRC; i++) begin
        if (m_mode[i]) begin
          if (cid == i + 1) np[i] = 1'b0;
          if (sr_we && sr_addr == A_PEND && sr_wdata[i]) np[i] = 1'b0;
          if (seen[i] && !m_prev[i]) np[i] = 1'b1;
        end else begin
          np[i] = seen[i];
        end
        if (cid == i + 1) ni[i] = 1'b1;
        if (wid == i + 1) ni[i] = 1'b0;
      end
      m_irq   <= (m_claim_val() != 0);
      m_pend  <= np;
      m_insvc <= ni;
      m_prev  <= seen;
      m_s1    <= src;
      m_s2    <= m_s1;
      if (sr_we && sr_addr == A_EN)   m_en   <= sr_wdata[NSRC-1:0];
      if (sr_we && sr_addr == A_MODE) m_mode <= sr_wdata[NSRC-1:0];
    end
  end

  // Per-cycle comparison against the model, well after the active edge.
  always @(posedge clk) begin
    #2;
    total++;
    if (irq !== m_irq) begin
      bad++;
      $display("FAIL model_irq t=%0t got=%0b want=%0b", $time, irq, m_irq);
    end
    total++;
    if (sr_rdata !== m_read(sr_addr)) begin
      bad++;
      $display("FAIL model_rdata t=%0t addr=%0h got=%0h want=%0h",
               $time, sr_addr, sr_rdata, m_read(sr_addr));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    sr_addr = a;
    #1;
    chk(name, sr_rdata, exp);
  endtask

  task automatic chk_irq(input logic exp, input string name);
    #1;
    chk(name, 32'(irq), 32'(exp));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sr_addr  = a;
    sr_wdata = d;
    sr_we    = 1'b1;
    @(negedge clk);
    sr_we    = 1'b0;
  endtask

  task automatic claim(input logic [31:0] exp, input string name);
    @(negedge clk);
    sr_addr = A_CLAIM;
    sr_re   = 1'b1;
    #1;
    chk(name, sr_rdata, exp);
    @(negedge clk);
    sr_re   = 1'b0;
  endtask

  task automatic pulse(input logic [NSRC-1:0] m, input int n);
    @(negedge clk);
    src = src | m;
    repeat (n) @(negedge clk);
    src = src & ~m;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; src = '0; sr_addr = '0; sr_we = 1'b0; sr_re = 1'b0; sr_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_rd(A_EN,    0, "rst_en");
    chk_rd(A_MODE,  0, "rst_mode");
    chk_rd(A_PEND,  0, "rst_pend");
    chk_rd(A_INSVC, 0, "rst_insvc");
    chk_rd(A_CLAIM, 0, "rst_claim");
    chk_irq(1'b0, "rst_irq");

    // single edge source
    wr(A_EN, 32'hFF);
    wr(A_MODE, 32'hFF);
    chk_rd(A_EN, 32'hFF, "en_rb");
    pulse(8'h08, 1);
    repeat (LAT - 2) @(negedge clk);
    chk_rd(A_PEND, 32'h08, "t1_pend");
    chk_irq(1'b0, "t1_irq_early");
    @(negedge clk);
    chk_irq(1'b1, "t1_irq");
    claim(4, "t1_claim");
    chk_rd(A_PEND, 0, "t1_pend_clr");
    chk_rd(A_INSVC, 32'h08, "t1_insvc");
    @(negedge clk);
    chk_irq(1'b0, "t1_irq_drop");
    wr(A_CMPL, 4);

    // two simultaneous sources
    pulse(8'h24, 1);
    repeat (LAT - 1) @(negedge clk);
    claim(3, "t2_claim3");
    claim(0, "t2_claim_masked");
    wr(A_CMPL, 3);
    @(negedge clk);
    chk_irq(1'b1, "t2_irq_re");
    claim(6, "t2_claim6");
    wr(A_CMPL, 6);

    // nesting
    pulse(8'h10, 1);
    repeat (LAT - 1) @(negedge clk);
    claim(5, "t3_claim5");
    pulse(8'h02, 1);
    repeat (LAT - 1) @(negedge clk);
    chk_irq(1'b1, "t3_irq_nest");
    claim(2, "t3_claim2");
    pulse(8'h40, 1);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk_irq(1'b0, "t3_irq_masked");
    end
    wr(A_CMPL, 2);
    @(negedge clk);
    chk_irq(1'b0, "t3_irq_still_masked");
    wr(A_CMPL, 5);
    @(negedge clk);
    chk_irq(1'b1, "t3_irq_src6");
    claim(7, "t3_claim7");
    wr(A_CMPL, 7);

    // level mode on source 0
    wr(A_MODE, 32'hFE);
    @(negedge clk);
    src = src | 8'h01;
    repeat (LAT) @(negedge clk);
    chk_irq(1'b1, "t4_irq");
    claim(1, "t4_claim");
    chk_rd(A_PEND, 32'h01, "t4_pend_held");
    chk_rd(A_INSVC, 32'h01, "t4_insvc");
    wr(A_CMPL, 1);
    @(negedge clk);
    chk_irq(1'b1, "t4_irq_re");
    @(negedge clk);
    src = src & ~8'h01;
    repeat (LAT - 1) @(negedge clk);
    chk_rd(A_PEND, 0, "t4_pend_drop");
    repeat (2) @(negedge clk);
    wr(A_MODE, 32'hFF);

    // new edge coincident with claim, W1C, bogus complete
    pulse(8'h04, 1);
    repeat (LAT - 1) @(negedge clk);
    chk_irq(1'b1, "t5_irq");
    @(negedge clk);
    src = src | 8'h04;
    repeat (LAT - 2) @(negedge clk);
    sr_addr = A_CLAIM;
    sr_re   = 1'b1;
    #1;
    chk("t5_claim", sr_rdata, 3);
    @(negedge clk);
    sr_re = 1'b0;
    src   = src & ~8'h04;
    chk_rd(A_PEND, 32'h04, "t5_pend_kept");
    wr(A_PEND, 32'h04);
    chk_rd(A_PEND, 0, "t5_pend_w1c");
    wr(A_CMPL, 7);
    chk_rd(A_INSVC, 32'h04, "t5_bogus_cmpl");
    wr(A_CMPL, 0);
    chk_rd(A_INSVC, 32'h04, "t5_zero_cmpl");
    wr(A_CMPL, 3);
    chk_rd(A_INSVC, 0, "t5_cmpl");

    // unmapped
    wr(32'h1016, 32'hFFFF_FFFF);
    chk_rd(32'h1016, 0, "unmapped_1016");
    chk_rd(32'h0FFF, 0, "unmapped_0fff");

    // reset mid-service
    pulse(8'h01, 1);
    repeat (LAT - 1) @(negedge clk);
    claim(1, "t6_claim");
    chk_rd(A_INSVC, 32'h01, "t6_insvc");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_rd(A_EN,    0, "t6_en");
    chk_rd(A_MODE,  0, "t6_mode");
    chk_rd(A_PEND,  0, "t6_pend");
    chk_rd(A_INSVC, 0, "t6_insvc_clr");
    chk_irq(1'b0, "t6_irq");

    // exact src-to-irq latency with a 2-cycle pulse
    wr(A_EN, 32'hFF);
    wr(A_MODE, 32'hFF);
    repeat (2) @(negedge clk);
    @(negedge clk);
    src = src | 8'h01;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk_irq(k == LAT, "t7_latency");
      if (k == 2) src = src & ~8'h01;
    end
    claim(1, "t7_claim");
    wr(A_CMPL, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
